timer_counter: RTL and testbench
================================

TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 Parameters: none; register map and widths are fixed.
REQ-002 clk  input  1  rising-edge clock shared with the CPU pipeline.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 addr  input  32  byte address from the CPU memory stage; only addr[3:2] is decoded.
REQ-005 we  input  1  write strobe, sampled on the rising clk edge.
REQ-006 be  input  4  byte enables for the write; be[0] selects wdata[7:0].
REQ-007 wdata  input  32  write data.
REQ-008 rdata  output  32  combinational read data for the word selected by addr[3:2].
REQ-009 irq  output  1  interrupt request to the CPU.

Function
REQ-010 Register map by addr[3:2] SHALL be: 0 = CTRL (R/W), 1 = PRESET (R/W), 2 = COUNT (read-only), 3 = reserved (reads 0, writes ignored).
REQ-011 CTRL bit fields SHALL be: [0] EN (enable); [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00); [3] IM (interrupt mask). Bits [31:4] SHALL read 0.
REQ-012 Writes to COUNT SHALL be ignored.
REQ-013 The FSM SHALL have four states, IDLE, LOAD, CNT and INT, with the following transitions:
- IDLE to LOAD when EN=1.
- LOAD: COUNT<=PRESET, then to CNT.
- CNT: if EN=0, to IDLE with COUNT held. Else if COUNT>1, COUNT<=COUNT-1. Else COUNT<=0 and to INT.
- INT, MODE 00: EN<=0, then to IDLE.
- INT, MODE 01: to LOAD.
REQ-014 irq_flag SHALL be set on the edge entering INT, so irq is visible during the INT cycle.
REQ-015 In MODE 00, irq_flag SHALL hold until any write to CTRL or PRESET.
REQ-016 In MODE 01, irq_flag SHALL clear on leaving INT, giving exactly a 1-cycle pulse.
REQ-017 irq SHALL equal irq_flag AND IM.
REQ-018 Latency:
- EN write at edge t gives LOAD during cycle t+1.
- COUNT=PRESET from edge t+2.
- For PRESET=P≥1, CNT lasts P cycles and is followed by one INT cycle.
- PRESET=0 behaves as PRESET=1.
REQ-019 Auto-reload period SHALL be P+2 cycles (LOAD + P×CNT + INT).
REQ-020 A software CTRL write in the same cycle as the INT-state EN clear SHALL win.
REQ-021 A PRESET write during CNT SHALL NOT affect the running COUNT; it takes effect at the next LOAD.
REQ-022 A CTRL write with EN=0 in any state SHALL force IDLE on the next edge and clear irq_flag.
REQ-023 COUNT arithmetic SHALL be 32-bit unsigned and SHALL never wrap below 0.

Reset
REQ-024 Asynchronous assertion of reset SHALL immediately clear CTRL, PRESET, COUNT and irq_flag, and force the FSM to IDLE.
REQ-025 While reset is asserted, irq SHALL be 0 and rdata SHALL reflect the cleared registers.
REQ-026 Reset asserted mid-count SHALL discard the count, and no irq SHALL follow release.

Configuration
REQ-027 With macro TC_BYTE_WRITE_EN defined, CTRL and PRESET writes SHALL update only the bytes whose be bit is 1; a write with be=0000 SHALL have no effect.
REQ-028 Without TC_BYTE_WRITE_EN, a write SHALL update the full word whenever we=1, and be SHALL be ignored.

Verification
REQ-029 Reset: assert reset asynchronously between clk edges -> rdata=0 at all three addresses, irq=0, immediately.
REQ-030 One-shot: PRESET=5, then CTRL=0x9.
- COUNT reads 5,4,3,2,1,0 on consecutive cycles.
- irq=1 from the INT cycle onward, and CTRL reads 0x8.
- A subsequent write CTRL=0x8 drops irq the next cycle.
REQ-031 Auto-reload: PRESET=3, CTRL=0xB -> irq is a 1-cycle pulse repeating every 5 cycles; COUNT reloads to 3 after each pulse.
REQ-032 Disable mid-count: PRESET=10, CTRL=0x9, then CTRL=0x0 when COUNT=4 -> IDLE with COUNT held at 4 and no irq; a rewrite of CTRL=0x9 reloads 10.
REQ-033 Byte write: PRESET=0xAABBCCDD, then a write with be=0011 and wdata=0x12345678 -> PRESET reads 0xAABB5678 with TC_BYTE_WRITE_EN, and 0x12345678 without it.
REQ-034 Masked interrupt and reset mid-run:
- PRESET=2, CTRL=0x1 -> irq stays 0 throughout, and CTRL reads 0x0 after INT.
- PRESET=100, CTRL=0x9, then reset asserted at COUNT=50 -> all registers 0 and irq never asserts after release.

Source files
------------

// File: rtl/timer_counter_if.sv
// CPU-side register bus for timer_counter: address/strobe/byte-enable/data and irq.
// No latency of its own; a bundle of wires.
// No backpressure: every access completes in the cycle it is presented.
//
// Signals:
//   addr  [31:0]  byte address, only addr[3:2] is decoded by the slave
//   we            write strobe, sampled on the rising clock edge
//   be    [3:0]   byte enables (honoured only in the byte-write build)
//   wdata [31:0]  write data
//   rdata [31:0]  combinational read data of the word selected by addr
//   irq           interrupt request to the CPU
interface timer_counter_if;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (
        output addr,
        output we,
        output be,
        output wdata,
        input  rdata,
        input  irq
    );

    modport slave (
        input  addr,
        input  we,
        input  be,
        input  wdata,
        output rdata,
        output irq
    );
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped down-counter timer with one-shot / auto-reload modes and a maskable irq.
// Reads are combinational; writes take effect on the next clk edge; EN write to LOAD is one cycle.
// No backpressure: the bus never stalls.
//
// Ports:
//   clk    rising-edge clock shared with the CPU pipeline
//   reset  asynchronous, active-high reset
//   bus    timer_counter_if.slave (addr, we, be, wdata in; rdata, irq out)
//
// Register map (addr[3:2]): 0 CTRL {IM, MODE[1:0], EN}, 1 PRESET, 2 COUNT (RO), 3 reserved.
// Build option: define TC_BYTE_WRITE_EN to make CTRL/PRESET writes honour be[3:0].
module timer_counter (
    input  logic           clk,
    input  logic           reset,
    timer_counter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PRESET = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [3:0]  r_ctrl;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_irq_flag;

    logic        w_wr_any;
    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic [31:0] w_ctrl_wval_full;
    logic [3:0]  w_ctrl_wval;
    logic [31:0] w_preset_wval;
    logic        w_unused;

    logic        w_en;
    logic        w_autoreload;
    logic        w_force_idle;
    logic        w_cnt_gt1;

    logic        w_load;
    logic        w_dec;
    logic        w_to_int;
    logic        w_int_clr_en;
    logic        w_int_exit;

`ifdef TC_BYTE_WRITE_EN
    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  be_v);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be_v[i]) begin
                res[i*8 +: 8] = new_v[i*8 +: 8];
            end
        end
        return res;
    endfunction

    // A write with no byte lanes enabled is not a write at all (no irq clear either).
    assign w_wr_any         = bus.we && (bus.be != 4'b0000);
    assign w_ctrl_wval_full = f_merge({28'd0, r_ctrl}, bus.wdata, bus.be);
    assign w_preset_wval    = f_merge(r_preset, bus.wdata, bus.be);
    assign w_unused         = ^{bus.addr[31:4], bus.addr[1:0], w_ctrl_wval_full[31:4]};
`else
    assign w_wr_any         = bus.we;
    assign w_ctrl_wval_full = bus.wdata;
    assign w_preset_wval    = bus.wdata;
    assign w_unused         = ^{bus.addr[31:4], bus.addr[1:0], bus.be, w_ctrl_wval_full[31:4]};
`endif

    assign w_ctrl_wval  = w_ctrl_wval_full[3:0];
    assign w_wr_ctrl    = w_wr_any && (bus.addr[3:2] == A_CTRL);
    assign w_wr_preset  = w_wr_any && (bus.addr[3:2] == A_PRESET);

    assign w_en         = r_ctrl[0];
    // MODE 1x behaves as one-shot, so only the exact 01 pattern reloads.
    assign w_autoreload = (r_ctrl[2:1] == 2'b01);
    // Software clearing EN overrides whatever the FSM would do this edge.
    assign w_force_idle = w_wr_ctrl && !w_ctrl_wval[0];
    assign w_cnt_gt1    = (r_count > 32'd1);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_en) w_state_nxt = ST_LOAD;
            ST_LOAD: w_state_nxt = ST_CNT;
            ST_CNT: begin
                if (!w_en) begin
                    w_state_nxt = ST_IDLE;
                end else if (!w_cnt_gt1) begin
                    w_state_nxt = ST_INT;
                end
            end
            ST_INT:  w_state_nxt = w_autoreload ? ST_LOAD : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_force_idle) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // ---------------- FSM: outputs ----------------
    // Datapath actions are qualified by the chosen next state, so a forced
    // IDLE also suppresses the load/decrement and COUNT is held.
    always_comb begin
        w_load       = 1'b0;
        w_dec        = 1'b0;
        w_to_int     = 1'b0;
        w_int_clr_en = 1'b0;
        w_int_exit   = 1'b0;
        case (r_state)
            ST_LOAD: w_load   = (w_state_nxt == ST_CNT);
            ST_CNT: begin
                // Staying in CNT implies COUNT > 1, so the decrement never wraps.
                w_dec    = (w_state_nxt == ST_CNT);
                w_to_int = (w_state_nxt == ST_INT);
            end
            ST_INT: begin
                w_int_clr_en = !w_autoreload;
                w_int_exit   = w_autoreload;
            end
            default: ;
        endcase
    end

    // ---------------- Registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl <= 4'd0;
        end else if (w_wr_ctrl) begin
            // Software write wins over the one-shot EN clear in the same cycle.
            r_ctrl <= w_ctrl_wval;
        end else if (w_int_clr_en) begin
            r_ctrl[0] <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_preset <= 32'd0;
        end else if (w_wr_preset) begin
            r_preset <= w_preset_wval;
        end
    end

    // PRESET is only sampled in LOAD, so a write during CNT waits for the next reload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 32'd0;
        end else if (w_load) begin
            r_count <= r_preset;
        end else if (w_to_int) begin
            r_count <= 32'd0;
        end else if (w_dec) begin
            r_count <= r_count - 32'd1;
        end
    end

    // One-shot: flag sticks until software touches CTRL/PRESET.
    // Auto-reload: flag drops as INT is left, giving a single-cycle pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq_flag <= 1'b0;
        end else if (w_to_int) begin
            r_irq_flag <= 1'b1;
        end else if (w_wr_ctrl || w_wr_preset) begin
            r_irq_flag <= 1'b0;
        end else if (w_int_exit) begin
            r_irq_flag <= 1'b0;
        end
    end

    // ---------------- Read mux and irq ----------------
    always_comb begin
        bus.rdata = 32'd0;
        case (bus.addr[3:2])
            A_CTRL:   bus.rdata = {28'd0, r_ctrl};
            A_PRESET: bus.rdata = r_preset;
            A_COUNT:  bus.rdata = r_count;
            default:  bus.rdata = 32'd0;
        endcase
    end

    assign bus.irq = r_irq_flag & r_ctrl[3];

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: stimulus pushes expected reads into a scoreboard.
// A monitor compares rdata/irq whenever a read is presented.
// Clocked at 10 ns; inputs change 1 ns after the rising edge.
module tb_timer_counter;

    logic clk = 1'b0;
    logic reset;

    timer_counter_if bus ();

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] A_CTRL   = 32'h0;
    localparam logic [31:0] A_PRESET = 32'h4;
    localparam logic [31:0] A_COUNT  = 32'h8;
    localparam logic [31:0] A_RSVD   = 32'hC;

`ifdef TC_BYTE_WRITE_EN
    localparam logic [31:0] EXP_BW1 = 32'hAABB5678;
    localparam logic [31:0] EXP_BW2 = 32'hAABB5678;
`else
    localparam logic [31:0] EXP_BW1 = 32'h12345678;
    localparam logic [31:0] EXP_BW2 = 32'hFFFFFFFF;
`endif

    typedef struct packed {
        logic [31:0] d;
        logic        i;
    } exp_t;

    exp_t  exp_q[$];
    string nm_q[$];
    event  rd_ev;
    int    checks = 0;
    int    errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        bus.addr  = a;
        bus.wdata = d;
        bus.be    = b;
        bus.we    = 1'b1;
        tick();
        bus.we    = 1'b0;
        bus.be    = 4'd0;
    endtask

    // Present a read and queue what it must return; takes 2 ns, no clock edge.
    task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic i, input string nm);
        exp_t e;
        bus.addr = a;
        #1;
        e.d = d;
        e.i = i;
        exp_q.push_back(e);
        nm_q.push_back(nm);
        ->rd_ev;
        #1;
    endtask

    // Monitor: pops one expectation per presented read.
    always begin
        exp_t  e;
        string n;
        @(rd_ev);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: read presented with nothing expected");
        end else begin
            e = exp_q.pop_front();
            n = nm_q.pop_front();
            if (bus.rdata !== e.d || bus.irq !== e.i) begin
                errors++;
                $display("FAIL %s: got rdata=%h irq=%b, expected rdata=%h irq=%b",
                         n, bus.rdata, bus.irq, e.d, e.i);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] AR_CNT [5] = '{32'd0, 32'd3, 32'd2, 32'd1, 32'd0};
    localparam logic        AR_IRQ [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        bus.addr  = 32'd0;
        bus.we    = 1'b0;
        bus.be    = 4'd0;
        bus.wdata = 32'd0;
        reset     = 1'b1;

        // Reset state
        #12;
        rd(A_CTRL,   32'd0, 1'b0, "rst_ctrl");
        rd(A_PRESET, 32'd0, 1'b0, "rst_preset");
        rd(A_COUNT,  32'd0, 1'b0, "rst_count");
        tick();
        reset = 1'b0;

        // Asynchronous reset between edges while counting
        wr(A_PRESET, 32'h55, 4'hF);
        wr(A_CTRL,   32'h9,  4'hF);
        tick();                                   // LOAD
        tick();                                   // CNT, COUNT=0x55
        rd(A_COUNT, 32'h55, 1'b0, "arst_pre_count");
        tick();
        #1;
        reset = 1'b1;
        rd(A_CTRL,   32'd0, 1'b0, "arst_ctrl");
        rd(A_PRESET, 32'd0, 1'b0, "arst_preset");
        rd(A_COUNT,  32'd0, 1'b0, "arst_count");
        tick();
        reset = 1'b0;

        // One-shot, PRESET=5, IM=1
        wr(A_PRESET, 32'd5, 4'hF);
        wr(A_CTRL,   32'h9, 4'hF);
        rd(A_COUNT, 32'd0, 1'b0, "os_idle");
        tick();
        rd(A_COUNT, 32'd0, 1'b0, "os_load");
        tick();
        for (int v = 5; v >= 1; v--) begin
            rd(A_COUNT, 32'(v), 1'b0, $sformatf("os_count%0d", v));
            tick();
        end
        rd(A_COUNT, 32'd0, 1'b1, "os_int");
        rd(A_CTRL,  32'h9, 1'b1, "os_int_ctrl");
        tick();
        rd(A_CTRL, 32'h8, 1'b1, "os_ctrl_after");
        tick();
        rd(A_CTRL, 32'h8, 1'b1, "os_irq_hold");
        wr(A_CTRL, 32'h8, 4'hF);
        rd(A_CTRL, 32'h8, 1'b0, "os_irq_clear");

        // PRESET=0 acts as 1; CTRL write during INT beats the EN clear
        wr(A_PRESET, 32'd0, 4'hF);
        wr(A_CTRL,   32'h9, 4'hF);
        tick();                                   // LOAD
        tick();                                   // CNT
        rd(A_COUNT, 32'd0, 1'b0, "p0_cnt");
        tick();                                   // INT
        rd(A_COUNT, 32'd0, 1'b1, "p0_int");
        wr(A_CTRL, 32'h9, 4'hF);
        rd(A_CTRL, 32'h9, 1'b0, "p0_sw_wins");
        tick();                                   // LOAD
        tick();                                   // CNT
        tick();                                   // INT
        rd(A_CTRL, 32'h9, 1'b1, "p0_int2");
        tick();
        rd(A_CTRL, 32'h8, 1'b1, "p0_en_clr");
        wr(A_CTRL, 32'h0, 4'hF);
        rd(A_CTRL, 32'h0, 1'b0, "p0_stop");

        // Auto-reload, PRESET=3: period of 5 with one-cycle irq pulse
        wr(A_PRESET, 32'd3, 4'hF);
        wr(A_CTRL,   32'hB, 4'hF);
        tick();                                   // first LOAD
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 5; i++) begin
                rd(A_COUNT, AR_CNT[i], AR_IRQ[i], $sformatf("ar_p%0d_c%0d", p, i));
                tick();
            end
        end
        wr(A_CTRL, 32'h0, 4'hF);
        rd(A_CTRL,  32'h0, 1'b0, "ar_stop_ctrl");
        rd(A_COUNT, 32'h0, 1'b0, "ar_stop_count");

        // Disable mid-count at COUNT=4, then re-enable
        wr(A_PRESET, 32'd10, 4'hF);
        wr(A_CTRL,   32'h9,  4'hF);
        tick();                                   // LOAD
        tick();                                   // COUNT=10
        for (int v = 10; v >= 5; v--) begin
            rd(A_COUNT, 32'(v), 1'b0, $sformatf("dis_count%0d", v));
            tick();
        end
        rd(A_COUNT, 32'd4, 1'b0, "dis_at4");
        wr(A_CTRL, 32'h0, 4'hF);
        rd(A_COUNT, 32'd4, 1'b0, "dis_held");
        tick();
        tick();
        rd(A_COUNT, 32'd4, 1'b0, "dis_held2");
        wr(A_COUNT, 32'h77, 4'hF);
        rd(A_COUNT, 32'd4, 1'b0, "count_ro");
        wr(A_RSVD, 32'hFF, 4'hF);
        rd(A_RSVD, 32'd0, 1'b0, "rsvd_zero");
        wr(A_CTRL, 32'h9, 4'hF);
        tick();                                   // LOAD
        tick();                                   // reloaded
        rd(A_COUNT, 32'd10, 1'b0, "dis_reload");
        wr(A_CTRL, 32'h0, 4'hF);

        // Byte-enable handling on PRESET
        wr(A_PRESET, 32'hAABBCCDD, 4'hF);
        rd(A_PRESET, 32'hAABBCCDD, 1'b0, "bw_full");
        wr(A_PRESET, 32'h12345678, 4'b0011);
        rd(A_PRESET, EXP_BW1, 1'b0, "bw_be0011");
        wr(A_PRESET, 32'hFFFFFFFF, 4'b0000);
        rd(A_PRESET, EXP_BW2, 1'b0, "bw_be0000");

        // Masked interrupt: IM=0, irq never rises, EN cleared after INT
        wr(A_PRESET, 32'd2, 4'hF);
        wr(A_CTRL,   32'h1, 4'hF);
        for (int i = 0; i < 5; i++) begin        // IDLE, LOAD, CNT, CNT, INT
            rd(A_CTRL, 32'h1, 1'b0, $sformatf("mask_c%0d", i));
            tick();
        end
        rd(A_CTRL,  32'h0, 1'b0, "mask_ctrl_after");
        rd(A_COUNT, 32'h0, 1'b0, "mask_count_after");

        // Reset mid-run at COUNT=50; no irq afterwards
        wr(A_PRESET, 32'd100, 4'hF);
        wr(A_CTRL,   32'h9,   4'hF);
        tick();                                   // LOAD
        tick();                                   // COUNT=100
        repeat (50) tick();
        rd(A_COUNT, 32'd50, 1'b0, "rm_count50");
        tick();
        #1;
        reset = 1'b1;
        rd(A_CTRL,   32'd0, 1'b0, "rm_ctrl");
        rd(A_PRESET, 32'd0, 1'b0, "rm_preset");
        rd(A_COUNT,  32'd0, 1'b0, "rm_count");
        tick();
        reset = 1'b0;
        for (int c = 0; c < 120; c++) begin
            rd(A_COUNT, 32'd0, 1'b0, $sformatf("rm_after%0d", c));
            tick();
        end

        tick();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d expectations unconsumed, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
